// File: rtl/lock_qualified_reset_sequencer.sv
// Lock-qualified reset sequencer: synchronises PLL lock, holds downstream reset
// for a programmable time, re-asserts it on filtered lock loss, and generates CE strobes + heartbeat.
module lock_qualified_reset_sequencer #(
  parameter int                        SYNC_STAGES = 2,
  parameter int                        HOLD_CYCLES = 65536,
  parameter int                        LOSS_FILTER = 16,
  parameter int                        N_CE        = 2,
  parameter int                        DIV_W       = 16,
  parameter logic [N_CE*DIV_W-1:0]     DIV_LIST    = {16'd12000, 16'd12},
  parameter int                        HB_DIV      = 8388608
) (
  input  logic            clk_in,
  input  logic            resetn_in,
  input  logic            lock_in,
  output logic            sys_resetn_out,
  output logic [N_CE-1:0] ce_out,
  output logic            hb_out,
  output logic [1:0]      state_out,
  output logic [7:0]      loss_cnt_out
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int FILT_W = $clog2(LOSS_FILTER + 1);
  localparam int HB_W   = $clog2(HB_DIV + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOSS_FILTER - 1);
  localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HB_DIV - 1);

  if (SYNC_STAGES < 2) begin : g_errSync
    $error("SYNC_STAGES must be at least 2");
  end
  if (HOLD_CYCLES < 1) begin : g_errHold
    $error("HOLD_CYCLES must be at least 1");
  end
  if (LOSS_FILTER < 1) begin : g_errFilt
    $error("LOSS_FILTER must be at least 1");
  end
  if (HB_DIV < 1) begin : g_errHb
    $error("HB_DIV must be at least 1");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    GLITCH    = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lockS;
  logic [HOLD_W-1:0]      r_holdCnt;
  logic [HOLD_W-1:0]      w_holdNext;
  logic [FILT_W-1:0]      r_filtCnt;
  logic [FILT_W-1:0]      w_filtNext;
  logic                   w_lossEvent;
  logic                   w_relNext;
  logic                   r_sysResetn;
  logic [7:0]             r_lossCnt;
  logic [HB_W-1:0]        r_hbCnt;
  logic                   r_hb;

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) r_sync <= '0;
    else            r_sync <= {r_sync[SYNC_STAGES-2:0], lock_in};
  end

  assign w_lockS = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_state   <= WAIT_LOCK;
      r_holdCnt <= '0;
      r_filtCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_holdCnt <= w_holdNext;
      r_filtCnt <= w_filtNext;
    end
  end

  // Loss of lock during HOLD wins over a completing hold count.
  always_comb begin
    w_stateNext = r_state;
    w_holdNext  = r_holdCnt;
    w_filtNext  = r_filtCnt;
    w_lossEvent = 1'b0;
    case (r_state)
      WAIT_LOCK: begin
        w_holdNext = '0;
        w_filtNext = '0;
        if (w_lockS) w_stateNext = HOLD;
      end
      HOLD: begin
        if (!w_lockS) begin
          w_stateNext = WAIT_LOCK;
          w_holdNext  = '0;
        end else if (r_holdCnt == HOLD_LAST) begin
          w_stateNext = RUN;
          w_holdNext  = '0;
        end else begin
          w_holdNext = r_holdCnt + 1'b1;
        end
      end
      RUN: begin
        if (!w_lockS) begin
          if (LOSS_FILTER == 1) begin
            w_stateNext = WAIT_LOCK;
            w_lossEvent = 1'b1;
          end else begin
            w_stateNext = GLITCH;
            w_filtNext  = FILT_W'(1);
          end
        end
      end
      GLITCH: begin
        if (w_lockS) begin
          w_stateNext = RUN;
          w_filtNext  = '0;
        end else if (r_filtCnt == FILT_LAST) begin
          w_stateNext = WAIT_LOCK;
          w_filtNext  = '0;
          w_lossEvent = 1'b1;
        end else begin
          w_filtNext = r_filtCnt + 1'b1;
        end
      end
      default: w_stateNext = WAIT_LOCK;
    endcase
  end

  always_comb begin
    w_relNext = (w_stateNext == RUN) || (w_stateNext == GLITCH);
    state_out = r_state;
  end

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_sysResetn <= 1'b0;
      r_lossCnt   <= '0;
    end else begin
      r_sysResetn <= w_relNext;
      if (w_lossEvent && (r_lossCnt != 8'hFF)) r_lossCnt <= r_lossCnt + 1'b1;
    end
  end

  assign sys_resetn_out = r_sysResetn;
  assign loss_cnt_out   = r_lossCnt;

  // Counters start on the first edge after release so every channel is aligned to it.
  for (genvar gi = 0; gi < N_CE; gi++) begin : g_ce
    localparam logic [DIV_W-1:0] DIV_I = DIV_LIST[gi*DIV_W +: DIV_W];
    logic r_ce;
    if (DIV_I <= 1) begin : g_const
      always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) r_ce <= 1'b0;
        else            r_ce <= w_relNext;
      end
    end else begin : g_count
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_I - 1'b1;
      logic [DIV_W-1:0] r_div;
      always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
          r_div <= '0;
          r_ce  <= 1'b0;
        end else if (!w_relNext || !r_sysResetn) begin
          r_div <= '0;
          r_ce  <= 1'b0;
        end else if (r_div == DIV_LAST) begin
          r_div <= '0;
          r_ce  <= 1'b1;
        end else begin
          r_div <= r_div + 1'b1;
          r_ce  <= 1'b0;
        end
      end
    end
    assign ce_out[gi] = r_ce;
  end

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_hbCnt <= '0;
      r_hb    <= 1'b0;
    end else if (r_hbCnt == HB_LAST) begin
      r_hbCnt <= '0;
      r_hb    <= ~r_hb;
    end else begin
      r_hbCnt <= r_hbCnt + 1'b1;
    end
  end

  assign hb_out = r_hb;

endmodule

// File: tb/tb_lock_qualified_reset_sequencer.sv
// Bench for lock_qualified_reset_sequencer: directed lock scenarios then random lock
// patterns, checked every cycle against a run-length model of the lock qualification rules.
module tb_lock_qualified_reset_sequencer;

  localparam int HOLD_CYCLES = 8;
  localparam int LOSS_FILTER = 4;
  localparam int N_CE        = 2;
  localparam int DIV_W       = 16;
  localparam int HB_DIV      = 5;
  localparam int SYNC_STAGES = 2;

  logic            clk_in = 1'b0;
  logic            resetn_in;
  logic            lock_in;
  logic            sys_resetn_out;
  logic [N_CE-1:0] ce_out;
  logic            hb_out;
  logic [1:0]      state_out;
  logic [7:0]      loss_cnt_out;

  int passCount  = 0;
  int checkCount = 0;

  // Model state: edges since reset release, lock sample pipeline, run lengths.
  int n;
  bit lockQ[$];
  bit mRel;
  int highRun;
  int lowRun;
  int relEdge;
  int mLoss;
  int divs[N_CE] = '{4, 3};
  int firstRise;
  bit prevSys;

  lock_qualified_reset_sequencer #(
    .SYNC_STAGES(SYNC_STAGES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .LOSS_FILTER(LOSS_FILTER),
    .N_CE(N_CE),
    .DIV_W(DIV_W),
    .DIV_LIST({16'd3, 16'd4}),
    .HB_DIV(HB_DIV)
  ) dut (
    .clk_in(clk_in),
    .resetn_in(resetn_in),
    .lock_in(lock_in),
    .sys_resetn_out(sys_resetn_out),
    .ce_out(ce_out),
    .hb_out(hb_out),
    .state_out(state_out),
    .loss_cnt_out(loss_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s at edge %0d: observed %0h, expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic modelReset();
    n       = 0;
    lockQ   = {};
    for (int i = 0; i < SYNC_STAGES; i++) lockQ.push_back(1'b0);
    mRel    = 1'b0;
    highRun = 0;
    lowRun  = 0;
    relEdge = 0;
    mLoss   = 0;
    prevSys = 1'b0;
  endtask

  // Lock must be seen high for the hold time plus the qualifying sample; loss is a run of lows.
  task automatic modelEdge();
    bit lockS;
    n++;
    lockS = lockQ.pop_front();
    lockQ.push_back(lock_in);
    if (!mRel) begin
      highRun = lockS ? highRun + 1 : 0;
      if (highRun == HOLD_CYCLES + 1) begin
        mRel    = 1'b1;
        relEdge = n;
        highRun = 0;
        lowRun  = 0;
      end
    end else begin
      lowRun = lockS ? 0 : lowRun + 1;
      if (lowRun == LOSS_FILTER) begin
        mRel    = 1'b0;
        lowRun  = 0;
        highRun = 0;
        if (mLoss < 255) mLoss++;
      end
    end
  endtask

  task automatic checkAll();
    logic [1:0]      expState;
    logic [N_CE-1:0] expCe;
    if (!mRel) expState = (highRun == 0) ? 2'd0 : 2'd1;
    else       expState = (lowRun == 0) ? 2'd2 : 2'd3;
    for (int i = 0; i < N_CE; i++)
      expCe[i] = mRel && (n > relEdge) && (((n - relEdge) % divs[i]) == 0);
    checkOutput("state", 32'(state_out), 32'(expState));
    checkOutput("sys_resetn", 32'(sys_resetn_out), 32'(mRel));
    checkOutput("ce", 32'(ce_out), 32'(expCe));
    checkOutput("hb", 32'(hb_out), 32'((n / HB_DIV) % 2));
    checkOutput("loss_cnt", 32'(loss_cnt_out), 32'(mLoss));
  endtask

  task automatic applyStimulus(input bit lockVal, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      lock_in = lockVal;
      @(posedge clk_in);
      #1;
      modelEdge();
      checkAll();
      if (!prevSys && sys_resetn_out && firstRise < 0) firstRise = n;
      prevSys = sys_resetn_out;
    end
  endtask

  task automatic checkZeros(input string tag);
    checkOutput({tag, "_sys"}, 32'(sys_resetn_out), 32'd0);
    checkOutput({tag, "_ce"}, 32'(ce_out), 32'd0);
    checkOutput({tag, "_hb"}, 32'(hb_out), 32'd0);
    checkOutput({tag, "_state"}, 32'(state_out), 32'd0);
    checkOutput({tag, "_loss"}, 32'(loss_cnt_out), 32'd0);
  endtask

  initial begin
    bit rv;
    int len;
    resetn_in = 1'b0;
    lock_in   = 1'b1;
    firstRise = -1;
    modelReset();
    #12;
    checkZeros("reset");
    @(negedge clk_in);
    resetn_in = 1'b1;

    $display("[TB] release with lock high");
    applyStimulus(1'b1, 30);
    checkOutput("first_rise_edge", 32'(firstRise), 32'd11);

    $display("[TB] short glitch in RUN");
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 10);
    checkOutput("glitch_loss", 32'(loss_cnt_out), 32'd0);

    $display("[TB] sustained loss in RUN");
    applyStimulus(1'b0, 6);
    checkOutput("loss_after_drop", 32'(loss_cnt_out), 32'd1);
    checkOutput("sys_after_drop", 32'(sys_resetn_out), 32'd0);
    applyStimulus(1'b1, 20);

    $display("[TB] lock drop during HOLD");
    applyStimulus(1'b0, 6);
    applyStimulus(1'b1, 7);
    applyStimulus(1'b0, 3);
    checkOutput("hold_abort_loss", 32'(loss_cnt_out), 32'd2);
    applyStimulus(1'b1, 15);

    $display("[TB] no lock, heartbeat only");
    applyStimulus(1'b0, 20);
    applyStimulus(1'b1, 25);
    checkOutput("run_before_reset", 32'(sys_resetn_out), 32'd1);

    $display("[TB] asynchronous reset mid-RUN");
    #3;
    resetn_in = 1'b0;
    #1;
    checkZeros("async");
    modelReset();
    lock_in = 1'b1;
    #2;
    @(negedge clk_in);
    resetn_in = 1'b1;

    $display("[TB] random lock patterns");
    for (int k = 0; k < 60; k++) begin
      rv  = ($urandom_range(0, 3) != 0);
      len = rv ? int'($urandom_range(1, 14)) : int'($urandom_range(1, 6));
      applyStimulus(rv, len);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/lock_qualified_reset_sequencer.md
Name: lock_qualified_reset_sequencer

Overview:
- Parametrised successor to the board-level power-on reset/clock-division logic: qualifies an asynchronous PLL lock, holds system reset for a programmable time, and releases it.
- Re-asserts reset on filtered lock loss and counts loss events.
- Generates N phase-aligned clock-enable strobes, which replace ripple-divided clocks, plus a free-running heartbeat for an LED.
- Sits between the oscillator/PLL primitives and all downstream logic (e.g. the frequency counter, OLED driver).

Parameters:
- SYNC_STAGES, 2: flops in the lock_in synchroniser; ≥2.
- HOLD_CYCLES, 65536: cycles spent in HOLD before release; ≥1.
- LOSS_FILTER, 16: consecutive low lock samples in RUN that constitute a loss; ≥1.
- N_CE, 2: number of clock-enable channels; ≥1.
- DIV_W, 16: width of each divider value.
- DIV_LIST, {16'd12000,16'd12}: packed divider values; channel i uses DIV_LIST[i*DIV_W +: DIV_W]. Default gives 1 MHz / 1 kHz from 12 MHz.
- HB_DIV, 8388608: heartbeat half-period in cycles; ≥1.

Ports:
- clk_in, in, 1: single system clock. All logic is on its rising edge.
- resetn_in, in, 1: asynchronous, active-low reset.
- lock_in, in, 1: PLL lock, asynchronous to clk_in.
- sys_resetn_out, out, 1: registered active-low reset for downstream logic.
- ce_out, out, N_CE: single-cycle clock-enable strobes.
- hb_out, out, 1: heartbeat square wave.
- state_out, out, 2: current FSM state encoding.
- loss_cnt_out, out, 8: saturating count of lock-loss events.

Behaviour:
- Reset (resetn_in low, asynchronous):
  - state = WAIT_LOCK.
  - Synchroniser, hold/filter/divider/heartbeat counters all cleared.
  - sys_resetn_out=0, ce_out=0, hb_out=0, loss_cnt_out=0, state_out=0.
- Synchronisation: lock_s = lock_in after SYNC_STAGES flops. The FSM uses only lock_s.
- FSM state encodings: WAIT_LOCK=0, HOLD=1, RUN=2, GLITCH=3.
- WAIT_LOCK:
  - lock_s=1 → HOLD, with hold counter = 0.
- HOLD:
  - Counts cycles in HOLD. After exactly HOLD_CYCLES cycles → RUN.
  - lock_s=0 at any point → WAIT_LOCK immediately, hold counter cleared, loss_cnt unchanged.
- RUN:
  - lock_s=0 → GLITCH with filter count = 1.
  - If LOSS_FILTER==1, go directly to WAIT_LOCK instead, with loss_cnt+1.
- GLITCH:
  - lock_s=1 → RUN, filter cleared, outputs unaffected.
  - LOSS_FILTER-th consecutive low sample → WAIT_LOCK, loss_cnt+1 (saturates at 255).
- sys_resetn_out:
  - Registered; 1 exactly while state ∈ {RUN, GLITCH}.
  - Rises on the same edge the state enters RUN; falls on the edge it enters WAIT_LOCK.
  - Latency from lock_s first high in WAIT_LOCK to sys_resetn_out high = HOLD_CYCLES+1 edges.
- ce_out[i]:
  - Per-channel counter held at 0 while sys_resetn_out=0.
  - While 1: counts 0..DIV_i-1 and wraps; ce_out[i] is registered high for one cycle each wrap.
  - First pulse is at the DIV_i-th edge after sys_resetn_out rises, so all channels are phase-aligned to release.
  - DIV_i ∈ {0,1}: ce_out[i] constantly 1 while sys_resetn_out=1.
  - Strobes continue through GLITCH; they stop and their counters clear on return to WAIT_LOCK.
- hb_out:
  - Free-running, independent of state and lock, so it blinks even when lock is never achieved.
  - Toggles every HB_DIV cycles.
- Width rules:
  - Hold counter is $clog2(HOLD_CYCLES+1) bits; filter counter is $clog2(LOSS_FILTER+1) bits.
  - No overflow is possible: comparisons are against the exact parameter value.
- Simultaneous events: resetn_in dominates everything. A lock_s transition on the cycle HOLD would complete takes priority: lock_s=0 → WAIT_LOCK, not RUN.
- Elaboration errors: HOLD_CYCLES=0, LOSS_FILTER=0, HB_DIV=0, SYNC_STAGES<2.

Test Plan:
All scenarios use HOLD_CYCLES=8, LOSS_FILTER=4, N_CE=2, DIV_LIST={3,4}, HB_DIV=5, SYNC_STAGES=2.
1. Release resetn_in with lock_in=1 → sys_resetn_out rises at edge 2+9=11 after reset release; state_out sequence 0→1→2.
2. After release → ce_out[0] pulses at edges 4,8,12 after the rise; ce_out[1] pulses at edges 3,6,9; each pulse is exactly 1 cycle wide.
3. In RUN, drop lock_in for 3 cycles then restore → state 2→3→2, sys_resetn_out stays 1, loss_cnt_out=0, strobes uninterrupted.
4. In RUN, drop lock_in for ≥4 cycles → sys_resetn_out falls 4 edges after lock_s goes low, loss_cnt_out=1, ce_out=0. Restore lock → re-release after 9 more edges with strobes re-aligned.
5. Drop lock in HOLD at hold count 5 → state returns to 0, loss_cnt_out unchanged. On re-lock the full 8-cycle hold is repeated.
6. Keep lock_in=0 for 20 cycles; hb_out toggles every 5 cycles. Assert resetn_in mid-RUN → all outputs 0 asynchronously, before the next edge.
